// File: rtl/pe_conv_mac_if.sv
// ---------------------------------------------------------------------------
// pe_conv_mac_if
//   Valid/ready bundle around the convolution MAC processing element.
//   Carries the filter-row input channel, the ifmap-window input channel and
//   the psum output channel.
//
//   filter_valid/ready/data : one filter row (3 weights) per handshake
//   ifmap_valid/ready/data  : one 3x3 ifmap window (9 elements) per handshake
//   psum_valid/ready/data   : one partial sum per window
//
//   slave  : the MAC (consumes filter/ifmap, produces psum)
//   master : the surroundings (depacketizer upstream, packetizer downstream)
// ---------------------------------------------------------------------------
interface pe_conv_mac_if #(
    parameter int FILTER_WIDTH = 8,
    parameter int IFMAP_WIDTH  = 1,
    parameter int PSUM_WIDTH   = 16
);
    logic                      filter_valid;
    logic                      filter_ready;
    logic [3*FILTER_WIDTH-1:0] filter_data;

    logic                      ifmap_valid;
    logic                      ifmap_ready;
    logic [9*IFMAP_WIDTH-1:0]  ifmap_data;

    logic                      psum_valid;
    logic                      psum_ready;
    logic [PSUM_WIDTH-1:0]     psum_data;

    modport slave (
        input  filter_valid, filter_data,
        output filter_ready,
        input  ifmap_valid, ifmap_data,
        output ifmap_ready,
        output psum_valid, psum_data,
        input  psum_ready
    );

    modport master (
        output filter_valid, filter_data,
        input  filter_ready,
        output ifmap_valid, ifmap_data,
        input  ifmap_ready,
        input  psum_valid, psum_data,
        output psum_ready
    );
endinterface

// File: rtl/pe_conv_mac.sv
// ---------------------------------------------------------------------------
// pe_conv_mac
//   Filter-stationary 3x3 MAC. Loads three filter rows, then for every ifmap
//   window accepted computes sum(w[i] * x[i]) over the 9 elements, one element
//   per cycle, and offers the result on the psum channel.
//
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   bus        : pe_conv_mac_if.slave (filter in, ifmap in, psum out)
//   busy       : high while a window is being accumulated or its psum is held
//   win_count  : number of completed psum handshakes, wraps 255 -> 0
//
//   PSUM_WIDTH must be at least FILTER_WIDTH + IFMAP_WIDTH + 4 so that a full
//   window of maximal products fits without wrapping.
// ---------------------------------------------------------------------------
module pe_conv_mac #(
    parameter int FILTER_WIDTH = 8,
    parameter int IFMAP_WIDTH  = 1,
    parameter int PSUM_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pe_conv_mac_if.slave         bus,
    output logic                 busy,
    output logic [7:0]           win_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_e;

    state_e                  state_q;
    logic [1:0]              filter_cnt_q;   // rows loaded, 3 = filter complete
    logic [FILTER_WIDTH-1:0] w_q [9];        // flat index = row*3 + col
    logic [IFMAP_WIDTH-1:0]  x_q [9];
    logic [PSUM_WIDTH-1:0]   acc_q;
    logic [3:0]              idx_q;
    logic                    psum_valid_q;
    logic [PSUM_WIDTH-1:0]   psum_data_q;
    logic [7:0]              win_count_q;

    logic                    filter_full;
    logic                    filter_fire;
    logic                    ifmap_fire;
    logic [1:0]              row_sel_d;
    logic [PSUM_WIDTH-1:0]   acc_d;

    assign filter_full = (filter_cnt_q == 2'd3);

    // A waiting ifmap outranks a new filter row once the filter is complete,
    // otherwise a stream of rows could starve the compute path.
    assign bus.filter_ready = (state_q == S_IDLE) && !(filter_full && bus.ifmap_valid);
    assign bus.ifmap_ready  = (state_q == S_IDLE) && filter_full;

    assign filter_fire = bus.filter_valid && bus.filter_ready;
    assign ifmap_fire  = bus.ifmap_valid  && bus.ifmap_ready;

    // A row arriving on a complete filter starts a fresh filter at row 0.
    assign row_sel_d = filter_full ? 2'd0 : filter_cnt_q;

    // Flat idx addresses w[idx/3][idx%3] directly; operands zero-extend and
    // the sum wraps at PSUM_WIDTH.
    assign acc_d = acc_q + PSUM_WIDTH'(w_q[idx_q]) * PSUM_WIDTH'(x_q[idx_q]);

    assign bus.psum_valid = psum_valid_q;
    assign bus.psum_data  = psum_data_q;
    assign busy           = (state_q != S_IDLE);
    assign win_count      = win_count_q;

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order. The weight
    // and window arrays are small register files, so they are reset with the
    // rest of the state rather than left uninitialised like a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            filter_cnt_q <= 2'd0;
            for (int i = 0; i < 9; i++) begin
                w_q[i] <= '0;
                x_q[i] <= '0;
            end
            acc_q        <= '0;
            idx_q        <= 4'd0;
            psum_valid_q <= 1'b0;
            psum_data_q  <= '0;
            win_count_q  <= 8'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (filter_fire) begin
                        for (int c = 0; c < 3; c++) begin
                            w_q[int'(row_sel_d) * 3 + c] <=
                                bus.filter_data[c*FILTER_WIDTH +: FILTER_WIDTH];
                        end
                        filter_cnt_q <= row_sel_d + 2'd1;
                    end
                    if (ifmap_fire) begin
                        for (int i = 0; i < 9; i++) begin
                            x_q[i] <= bus.ifmap_data[i*IFMAP_WIDTH +: IFMAP_WIDTH];
                        end
                        acc_q   <= '0;
                        idx_q   <= 4'd0;
                        state_q <= S_MAC;
                    end
                end

                S_MAC: begin
                    acc_q <= acc_d;
                    if (idx_q == 4'd8) begin
                        psum_data_q  <= acc_d;
                        psum_valid_q <= 1'b1;
                        state_q      <= S_OUT;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end

                S_OUT: begin
                    if (bus.psum_ready) begin
                        psum_valid_q <= 1'b0;
                        win_count_q  <= win_count_q + 8'd1;
                        state_q      <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_conv_mac.sv
// ---------------------------------------------------------------------------
// tb_pe_conv_mac
//   Directed bench for pe_conv_mac. Inputs change on the falling edge or just
//   after a rising edge; outputs are sampled 1 time unit after an edge.
// ---------------------------------------------------------------------------
module tb_pe_conv_mac;

    localparam int FW = 8;
    localparam int XW = 1;
    localparam int PW = 16;
    localparam int BUDGET = 50;

    logic clk;
    logic rst_n;
    logic busy;
    logic [7:0] win_count;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_win  = 0;

    pe_conv_mac_if #(.FILTER_WIDTH(FW), .IFMAP_WIDTH(XW), .PSUM_WIDTH(PW)) bus ();

    pe_conv_mac #(.FILTER_WIDTH(FW), .IFMAP_WIDTH(XW), .PSUM_WIDTH(PW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .busy      (busy),
        .win_count (win_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Offer one filter row {w0,w1,w2} and hold it until accepted.
    task automatic send_row(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2);
        int n;
        @(negedge clk);
        bus.filter_valid = 1'b1;
        bus.filter_data  = {w2, w1, w0};
        #1;
        n = 0;
        while (!bus.filter_ready && n < BUDGET) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= BUDGET) check({tag, "_row_timeout"}, 0, 1);
        @(posedge clk);
        #1;
        bus.filter_valid = 1'b0;
    endtask

    task automatic load_filter(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d, input logic [7:0] e,
                               input logic [7:0] f, input logic [7:0] g, input logic [7:0] h,
                               input logic [7:0] i);
        send_row(tag, a, b, c);
        send_row(tag, d, e, f);
        send_row(tag, g, h, i);
    endtask

    // Offer a window, wait for the psum, check latency and value, but do not
    // accept it yet.
    task automatic start_window(input string tag, input logic [8:0] x, input logic [15:0] exp);
        int n;
        int lat;
        @(negedge clk);
        bus.ifmap_valid = 1'b1;
        bus.ifmap_data  = x;
        #1;
        n = 0;
        while (!bus.ifmap_ready && n < BUDGET) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= BUDGET) check({tag, "_ifmap_timeout"}, 0, 1);
        @(posedge clk);
        #1;
        bus.ifmap_valid = 1'b0;
        check({tag, "_busy"}, busy, 1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.psum_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, lat, 9);
        check({tag, "_psum"}, bus.psum_data, exp);
    endtask

    task automatic accept_psum(input string tag);
        @(negedge clk);
        bus.psum_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.psum_ready = 1'b0;
        exp_win = (exp_win + 1) % 256;
        check({tag, "_valid_drop"}, bus.psum_valid, 0);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_win_count"}, win_count, exp_win);
    endtask

    task automatic run_window(input string tag, input logic [8:0] x, input logic [15:0] exp);
        start_window(tag, x, exp);
        accept_psum(tag);
    endtask

    initial begin
        logic [15:0] held;

        rst_n            = 1'b0;
        bus.filter_valid = 1'b0;
        bus.filter_data  = '0;
        bus.ifmap_valid  = 1'b0;
        bus.ifmap_data   = '0;
        bus.psum_ready   = 1'b0;

        #12;
        check("rst_psum_valid", bus.psum_valid, 0);
        check("rst_psum_data", bus.psum_data, 0);
        check("rst_busy", busy, 0);
        check("rst_win_count", win_count, 0);
        check("rst_ifmap_ready", bus.ifmap_ready, 0);
        check("rst_filter_ready", bus.filter_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: rows [1,2,3],[4,5,6],[7,8,9], all-ones window -> 45
        send_row("t1", 8'd1, 8'd2, 8'd3);
        check("t1_partial_ifmap_ready", bus.ifmap_ready, 0);
        send_row("t1", 8'd4, 8'd5, 8'd6);
        send_row("t1", 8'd7, 8'd8, 8'd9);
        check("t1_full_ifmap_ready", bus.ifmap_ready, 1);
        run_window("t1", 9'h1FF, 16'd45);

        // T2: filter stays loaded; single elements and a sparse pattern
        run_window("t2a", 9'h001, 16'd1);
        run_window("t2b", 9'h100, 16'd9);
        run_window("t2c", 9'h0AA, 16'd20);   // 2+4+6+8
        run_window("t2d", 9'h000, 16'd0);

        // T3: downstream stall in OUT
        start_window("t3", 9'h111, 16'd15);  // 1+5+9
        held = bus.psum_data;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("t3_hold_valid", bus.psum_valid, 1);
            check("t3_hold_data", bus.psum_data, held);
            check("t3_hold_ifmap_ready", bus.ifmap_ready, 0);
            check("t3_hold_filter_ready", bus.filter_ready, 0);
        end
        accept_psum("t3");

        // T4: a row on a full filter restarts loading
        send_row("t4", 8'd10, 8'd10, 8'd10);
        check("t4_ifmap_ready_after_1", bus.ifmap_ready, 0);
        send_row("t4", 8'd10, 8'd10, 8'd10);
        check("t4_ifmap_ready_after_2", bus.ifmap_ready, 0);
        send_row("t4", 8'd10, 8'd10, 8'd10);
        run_window("t4", 9'h1FF, 16'd90);

        // T5: maximal weights, then ifmap priority over filter
        load_filter("t5", 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
                    8'd255, 8'd255, 8'd255);
        run_window("t5a", 9'h1FF, 16'd2295);
        @(negedge clk);
        bus.ifmap_valid  = 1'b1;
        bus.ifmap_data   = 9'h1FF;
        bus.filter_valid = 1'b1;
        bus.filter_data  = {8'd1, 8'd1, 8'd1};
        #1;
        check("t5_prio_filter_ready", bus.filter_ready, 0);
        check("t5_prio_ifmap_ready", bus.ifmap_ready, 1);
        @(posedge clk);
        #1;
        bus.ifmap_valid  = 1'b0;
        bus.filter_valid = 1'b0;
        check("t5_prio_busy", busy, 1);
        for (int k = 0; k < 9; k++) @(posedge clk);
        #1;
        check("t5_prio_valid", bus.psum_valid, 1);
        check("t5_prio_psum", bus.psum_data, 2295);   // filter unchanged
        accept_psum("t5b");

        // win_count wrap 255 -> 0 using the loaded filter
        while (exp_win != 0) run_window("wrap", 9'h001, 16'd255);
        check("wrap_zero", win_count, 0);

        // T6: reset in the middle of a window
        run_window("t6_pre", 9'h003, 16'd510);
        @(negedge clk);
        bus.ifmap_valid = 1'b1;
        bus.ifmap_data  = 9'h1FF;
        @(posedge clk);
        #1;
        bus.ifmap_valid = 1'b0;
        for (int k = 0; k < 4; k++) @(posedge clk);   // idx now 4
        #2;
        rst_n = 1'b0;
        exp_win = 0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_psum_valid", bus.psum_valid, 0);
        check("t6_rst_psum_data", bus.psum_data, 0);
        check("t6_rst_win_count", win_count, 0);
        check("t6_rst_ifmap_ready", bus.ifmap_ready, 0);
        check("t6_rst_filter_ready", bus.filter_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.ifmap_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("t6_no_filter_ifmap_ready", bus.ifmap_ready, 0);
            check("t6_no_filter_busy", busy, 0);
        end
        bus.ifmap_valid = 1'b0;

        // Reload after reset and confirm the filter really was cleared/reloaded
        load_filter("t6", 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
        run_window("t6_post", 9'h1FF, 16'd9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
